// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default frame parameters
// and frame format descriptor used by uart_tx and uart_rx.
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_START     = 3'd1;
  localparam state_t ST_DATA      = 3'd2;
  localparam state_t ST_STOP      = 3'd3;
  localparam state_t ST_WAIT_IDLE = 3'd4;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  typedef struct packed {
    logic [3:0] data_bits;
    logic [1:0] parity;
    logic [1:0] stop_bits;
  } frame_fmt_t;

  localparam frame_fmt_t FRAME_8N1 = '{
    data_bits: 4'd8,
    parity:    PARITY_NONE,
    stop_bits: 2'd1
  };

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Reset value is a parameter so idle-high lines stay quiet.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames recovered with an oversampling strobe,
// one-clock valid and frame_err pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = cnt_w(OVERSAMPLE);
  localparam int BW = cnt_w(DATA_BITS);

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state, state_d;
  logic [TW-1:0]        tick_cnt, tick_d, tick_inc;
  logic [BW-1:0]        bit_cnt, bit_d;
  logic [DATA_BITS-1:0] sr, sr_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, ferr_d;
  logic                 t_mid, t_end;

  uart_rx_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign tick_inc = tick_cnt + TW'(1);
  assign t_mid    = (tick_cnt == T_HALF);
  assign t_end    = (tick_cnt == T_FULL);

  always_comb begin
    state_d = state;
    tick_d  = tick_cnt;
    bit_d   = bit_cnt;
    sr_d    = sr;
    data_d  = data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else if (sample_tick) begin
      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            tick_d  = '0;
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (!t_mid) begin
            tick_d = tick_inc;
          end else if (!rx_s) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (!t_end) begin
            tick_d = tick_inc;
          end else begin
            tick_d = '0;
            sr_d   = {rx_s, sr[DATA_BITS-1:1]};
            if (bit_cnt == B_LAST) begin
              state_d = ST_STOP;
            end else begin
              bit_d = bit_cnt + BW'(1);
            end
          end
        end
        ST_STOP: begin
          if (!t_end) begin
            tick_d = tick_inc;
          end else begin
            tick_d = '0;
            // Leaving at mid stop bit lets the next start edge land in IDLE.
            if (rx_s) begin
              data_d  = sr;
              valid_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      tick_cnt  <= tick_d;
      bit_cnt   <= bit_d;
      sr        <= sr_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= ferr_d;
      busy      <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level model queues expected
// bytes and framing errors; a negedge process checks every cycle.
module tb_uart_rx;

  localparam int OS   = 16;
  localparam int TDIV = 4;
  localparam int FRAME_CLKS = 10 * OS * TDIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       rx  = 1'b1;
  logic       sample_tick;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int     div = 0;
  longint cyc = 0;

  logic [7:0] exp_q[$];
  longint     vcyc[$];
  int         ferr_pend = 0;
  logic [7:0] model_data = 8'h00;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  bit         saw_busy = 1'b0;

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (OS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sample_tick (sample_tick),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div <= (div == TDIV - 1) ? 0 : div + 1;
    cyc <= cyc + 1;
  end

  assign sample_tick = (div == TDIV - 1);

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      model_data = 8'h00;
    end else begin
      if (valid) begin
        valid_cnt++;
        vcyc.push_back(cyc);
        chk("valid_was_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) model_data = exp_q.pop_front();
      end
      if (frame_err) begin
        ferr_cnt++;
        chk("ferr_was_expected", 32'(ferr_pend > 0), 1);
        if (ferr_pend > 0) ferr_pend--;
      end
      chk("data", data, model_data);
      chk("valid_ferr_excl", 32'(valid & frame_err), 0);
      if (busy) saw_busy = 1'b1;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk iff sample_tick);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    else ferr_pend++;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ferr_pend != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, 32'(exp_q.size() == 0 && ferr_pend == 0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int base_v;
    int base_f;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    en  = 1'b1;
    wait_ticks(4);

    send_frame(8'hB4, 1'b1);
    drain("loop_drain");
    chk("loop_data", data, 8'hB4);
    chk("loop_count", valid_cnt, 1);
    chk("loop_ferr", ferr_cnt, 0);
    chk("loop_busy_idle", busy, 0);

    vcyc.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    drain("b2b_drain");
    chk("b2b_count", vcyc.size(), 3);
    if (vcyc.size() == 3) begin
      chk("b2b_gap1", 32'(vcyc[1] - vcyc[0]), FRAME_CLKS);
      chk("b2b_gap2", 32'(vcyc[2] - vcyc[1]), FRAME_CLKS);
    end
    chk("b2b_data", data, 8'hA5);

    wait_ticks(4);
    saw_busy = 1'b0;
    base_v = valid_cnt;
    base_f = ferr_cnt;
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(12);
    chk("glitch_busy_seen", saw_busy, 1);
    chk("glitch_busy_low", busy, 0);
    chk("glitch_no_valid", valid_cnt, base_v);
    chk("glitch_no_ferr", ferr_cnt, base_f);

    base_f = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    wait_ticks(40);
    chk("ferr_count", ferr_cnt, base_f + 1);
    chk("ferr_data_kept", data, 8'hA5);
    chk("ferr_busy_wait", busy, 1);
    rx = 1'b1;
    wait_ticks(4);
    chk("ferr_busy_release", busy, 0);
    send_frame(8'h5A, 1'b1);
    drain("ferr_next_drain");
    chk("ferr_next_data", data, 8'h5A);

    base_v = valid_cnt;
    b = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    en = 1'b0;
    rx = 1'b1;
    wait_ticks(2);
    chk("abort_busy", busy, 0);
    wait_ticks(10);
    en = 1'b1;
    wait_ticks(4);
    chk("abort_no_valid", valid_cnt, base_v);
    send_frame(8'h81, 1'b1);
    drain("abort_next_drain");
    chk("abort_next_data", data, 8'h81);

    base_v = valid_cnt;
    b = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 0);
    wait_ticks(2);
    rst = 1'b1;
    for (int i = 4; i < 8; i++) drive_bit(b[i]);
    drive_bit(1'b1);
    wait_ticks(8);
    chk("mid_rst_no_valid", valid_cnt, base_v);
    send_frame(8'h3A, 1'b1);
    drain("mid_rst_next_drain");
    chk("mid_rst_next_data", data, 8'h3A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
